// File: rtl/fx2_channel_arbiter.sv
// Round-robin arbiter draining fixed-size channel packets into the single FX2 output stream.
// Optional per-packet header word enabled by defining FX2_ARB_HEADER_EN.
module fx2_channel_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int PKT_WORDS  = 256,
    parameter int GAP_CYCLES = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_CH-1:0]      ch_pkt_rdy,
    input  logic [16*NUM_CH-1:0]   ch_data,
    output logic [NUM_CH-1:0]      ch_rd_en,
    input  logic                   fx2_ready,
    output logic [15:0]            out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [3:0]             grant_ch,
    output logic                   busy
);

    localparam int              CNT_W    = $clog2(PKT_WORDS + 1);
    localparam logic [CNT_W-1:0] PKT_L    = CNT_W'(PKT_WORDS);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_WORDS - 1);
    localparam logic [5:0]       GAP_LAST = 6'(GAP_CYCLES - 1);
    localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);
    localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_XFER,
        ST_GAP
`ifdef FX2_ARB_HEADER_EN
        , ST_HDR
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       rr_q, rr_d;
    logic [3:0]       grant_q, grant_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [5:0]       gap_q, gap_d;
    logic [15:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
`ifdef FX2_ARB_HEADER_EN
    logic [7:0]       seq_q, seq_d;
`endif

    logic             strobe;
    logic             found;
    logic [3:0]       pick;
    logic [4:0]       idx;
    logic [15:0]      req_ext;
    logic [15:0]      sel_data;

    assign req_ext = 16'(ch_pkt_rdy);

    // Cyclic search for the first requester starting at the rr pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found = 1'b0;
        pick  = rr_q;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_q} + 5'(i);
            if (idx >= NUM_CH_L) idx = idx - NUM_CH_L;
            if (!found && req_ext[idx[3:0]]) begin
                found = 1'b1;
                pick  = idx[3:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_q == 4'(k)) sel_data = ch_data[16*k +: 16];
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        wcnt_d  = wcnt_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        strobe  = 1'b0;
`ifdef FX2_ARB_HEADER_EN
        seq_d   = seq_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enable && (|ch_pkt_rdy)) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (found) begin
                    grant_d = pick;
                    rr_d    = (pick == CH_LAST) ? 4'd0 : pick + 4'd1;
                    wcnt_d  = '0;
`ifdef FX2_ARB_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_XFER;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef FX2_ARB_HEADER_EN
            ST_HDR: begin
                if (fx2_ready) begin
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    data_d  = {4'hA, grant_q, seq_q};
                    seq_d   = seq_q + 8'd1;
                    state_d = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                strobe = fx2_ready && (wcnt_q < PKT_L);
                if (strobe) begin
                    wcnt_d  = wcnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                    data_d  = sel_data;
`ifndef FX2_ARB_HEADER_EN
                    sop_d   = (wcnt_q == '0);
`endif
                    eop_d   = (wcnt_q == PKT_LAST);
                end
                // The last strobed word is on the output this cycle.
                if (wcnt_q == PKT_L) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read strobe stays low during reset so no FIFO word is lost while aborting.
    always_comb begin
        ch_rd_en = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rd_en[k] = strobe && !reset && (grant_q == 4'(k));
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            wcnt_q  <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
`ifdef FX2_ARB_HEADER_EN
            seq_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            wcnt_q  <= wcnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
`ifdef FX2_ARB_HEADER_EN
            seq_q   <= seq_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign grant_ch  = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fx2_channel_arbiter.sv
// Scoreboard bench for fx2_channel_arbiter: counter-pattern FIFO models feed the arbiter and
// every output word is compared against expected packets queued when each packet is requested.
module tb_fx2_channel_arbiter;

    localparam int NUM_CH = 4;
    localparam int PKT    = 256;
`ifdef FX2_ARB_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int PW_OUT = PKT + (HDR ? 1 : 0);

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic [3:0]  ch;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [NUM_CH-1:0]    ch_pkt_rdy;
    logic [16*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_rd_en;
    logic                 fx2_ready;
    logic [15:0]          out_data;
    logic                 out_valid;
    logic                 out_sop;
    logic                 out_eop;
    logic [3:0]           grant_ch;
    logic                 busy;

    exp_t       sb[$];
    logic [11:0] fifo_cnt [NUM_CH];
    logic [11:0] exp_cnt  [NUM_CH];
    logic [7:0]  hdr_seq;
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          words_seen = 0;
    int          last_eop_cyc = -1;

    fx2_channel_arbiter #(.NUM_CH(NUM_CH), .PKT_WORDS(PKT), .GAP_CYCLES(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ch_pkt_rdy(ch_pkt_rdy),
        .ch_data   (ch_data),
        .ch_rd_en  (ch_rd_en),
        .fx2_ready (fx2_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .grant_ch  (grant_ch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // First-word-fall-through FIFO model: head word is {channel, running count}.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (reset) fifo_cnt[k] <= '0;
            else if (ch_rd_en[k]) fifo_cnt[k] <= fifo_cnt[k] + 12'd1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_data
        assign ch_data[16*k +: 16] = {4'(k), fifo_cnt[k]};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ch_rd_en != '0) begin
            check("rd_onehot", 32'($countones(ch_rd_en)), 32'd1);
            check("rd_ready", {31'd0, fx2_ready}, 32'd1);
        end
        if (out_valid) begin
            words_seen++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("data", {16'd0, out_data}, {16'd0, e.data});
                check("sop", {31'd0, out_sop}, {31'd0, e.sop});
                check("eop", {31'd0, out_eop}, {31'd0, e.eop});
                check("grant", {28'd0, grant_ch}, {28'd0, e.ch});
            end
            if (out_sop && last_eop_cyc >= 0) check("ipg", 32'(cyc - last_eop_cyc), 32'd10);
            if (out_eop) last_eop_cyc = cyc;
        end
    end

    task automatic push_pkt(input int ch);
        exp_t e;
        if (HDR) begin
            e.data = {4'hA, 4'(ch), hdr_seq};
            e.sop  = 1'b1;
            e.eop  = 1'b0;
            e.ch   = 4'(ch);
            sb.push_back(e);
            hdr_seq = hdr_seq + 8'd1;
        end
        for (int i = 0; i < PKT; i++) begin
            e.data = {4'(ch), exp_cnt[ch]};
            e.sop  = (i == 0) && !HDR;
            e.eop  = (i == PKT - 1);
            e.ch   = 4'(ch);
            sb.push_back(e);
            exp_cnt[ch] = exp_cnt[ch] + 12'd1;
        end
    endtask

    task automatic flush_model();
        sb.delete();
        for (int k = 0; k < NUM_CH; k++) exp_cnt[k] = '0;
        hdr_seq      = '0;
        words_seen   = 0;
        last_eop_cyc = -1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        ch_pkt_rdy = '0;
        fx2_ready  = 1'b1;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {28'd0, grant_ch}, 32'd0);
        check("rst_rd_en", 32'(ch_rd_en), 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (words_seen >= n) break;
        end
        if (c == budget) check("timeout_words", 32'(words_seen), 32'(n));
    endtask

    task automatic wait_busy(input logic val, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (busy === val) break;
        end
        if (c == budget) check("timeout_busy", {31'd0, busy}, {31'd0, val});
    endtask

    initial begin
        reset = 1'b1;
        // Single packet on channel 0, then busy falls 7 cycles after eop.
        do_reset();
        push_pkt(0);
        ch_pkt_rdy = 4'b0001;
        enable     = 1'b1;
        wait_words(1, 50);
        ch_pkt_rdy = '0;
        wait_words(PW_OUT, 2000);
        wait_busy(1'b0, 50);
        check("busy_fall", 32'(cyc - last_eop_cyc), 32'd7);
        check("t1_words", 32'(words_seen), 32'(PW_OUT));
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // All channels requesting: grants 0,1,2,3,0 with fixed inter-packet spacing.
        do_reset();
        push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(0);
        ch_pkt_rdy = 4'b1111;
        enable     = 1'b1;
        wait_words(4 * PW_OUT + 1, 4000);
        enable = 1'b0;
        wait_busy(1'b0, 2000);
        check("t2_words", 32'(words_seen), 32'(5 * PW_OUT));
        check("t2_sb_empty", 32'(sb.size()), 32'd0);
        check("t2_last_grant", {28'd0, grant_ch}, 32'd0);

        // fx2_ready toggling every cycle on channel 3.
        do_reset();
        push_pkt(3);
        ch_pkt_rdy = 4'b1000;
        enable     = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            fx2_ready = ~fx2_ready;
            if (words_seen > 0) ch_pkt_rdy = '0;
            if (words_seen >= PW_OUT && !busy) break;
        end
        fx2_ready = 1'b1;
        check("t3_words", 32'(words_seen), 32'(PW_OUT));
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        check("t3_idle", {31'd0, busy}, 32'd0);

        // enable dropped mid-packet: packet completes, then no new grant.
        do_reset();
        push_pkt(0);
        ch_pkt_rdy = 4'b1111;
        enable     = 1'b1;
        wait_words(100, 500);
        enable = 1'b0;
        wait_busy(1'b0, 2000);
        repeat (40) @(negedge clk);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_words", 32'(words_seen), 32'(PW_OUT));
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-packet on channel 1; next grant restarts from channel 0.
        do_reset();
        push_pkt(1);
        ch_pkt_rdy = 4'b0010;
        enable     = 1'b1;
        wait_words(50, 500);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rd_en", 32'(ch_rd_en), 32'd0);
        check("t5_grant", {28'd0, grant_ch}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        flush_model();
        push_pkt(0);
        ch_pkt_rdy = 4'b1111;
        reset      = 1'b0;
        wait_words(1, 50);
        enable = 1'b0;
        wait_words(PW_OUT, 2000);
        wait_busy(1'b0, 50);
        check("t5_words", 32'(words_seen), 32'(PW_OUT));
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

`ifdef FX2_ARB_HEADER_EN
        // Three header-prefixed packets on channel 2: A200, A201, A202.
        do_reset();
        push_pkt(2); push_pkt(2); push_pkt(2);
        ch_pkt_rdy = 4'b0100;
        enable     = 1'b1;
        wait_words(2 * PW_OUT + 1, 3000);
        enable = 1'b0;
        wait_busy(1'b0, 2000);
        check("hdr_words", 32'(words_seen), 32'(3 * PW_OUT));
        check("hdr_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
